// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Purpose  : Microwave-style digit entry buffer (M:ST:SO) and three-cycle
//            load sequencer driving the timer's shared load bus.
//            Optional feature macro: ENTRY_RANGE_CHECK_EN (rejects start when
//            the tens digit exceeds 5 or the entry is all zeros).
// Ports    : clock      - system clock, rising edge
//            clearn     - synchronous reset, active-low
//            key_valid  - one-cycle key strobe
//            key_code   - 0-9 digit, 10 cancel, 11-15 ignored
//            start      - one-cycle load request
//            data_out   - digit presented to the timer load bus
//            loadn      - active-low load strobe
//            disp_mins/disp_tens/disp_ones - entry buffer for the display
//            loading    - high during the three load cycles
//            loaded     - one-cycle pulse after the last load cycle
//            err        - one-cycle pulse when start is rejected
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry (
  input  logic       clock,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  output logic [3:0] data_out,
  output logic       loadn,
  output logic [3:0] disp_mins,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       loading,
  output logic       loaded,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_M = 3'd1,
    S_LD_T = 3'd2,
    S_LD_O = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] C_KEY_CANCEL = 4'd10;
  localparam logic [3:0] C_KEY_MAXDIG = 4'd9;

  state_t     state_q;
  logic [3:0] m_q, t_q, o_q;
  logic [1:0] cnt_q;
  logic [3:0] data_q;
  logic       loadn_q, loading_q, loaded_q, err_q;

  // Buffer as it would look after this cycle's key; start is judged against it
  // so a key and start arriving together load the new digit.
  logic [3:0] m_d, t_d, o_d;
  logic [1:0] cnt_d;
  logic       start_ok_w;

  always_comb begin
    m_d   = m_q;
    t_d   = t_q;
    o_d   = o_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE && key_valid) begin
      if (key_code <= C_KEY_MAXDIG) begin
        if (cnt_q != 2'd3) begin
          m_d   = t_q;
          t_d   = o_q;
          o_d   = key_code;
          cnt_d = cnt_q + 2'd1;
        end
      end else if (key_code == C_KEY_CANCEL) begin
        m_d   = 4'd0;
        t_d   = 4'd0;
        o_d   = 4'd0;
        cnt_d = 2'd0;
      end
    end
  end

`ifdef ENTRY_RANGE_CHECK_EN
  assign start_ok_w = (cnt_d != 2'd0) && (t_d <= 4'd5) &&
                      !((m_d == 4'd0) && (t_d == 4'd0) && (o_d == 4'd0));
`else
  assign start_ok_w = (cnt_d != 2'd0);
`endif

  always_ff @(posedge clock) begin
    if (!clearn) begin
      state_q   <= S_IDLE;
      m_q       <= 4'd0;
      t_q       <= 4'd0;
      o_q       <= 4'd0;
      cnt_q     <= 2'd0;
      data_q    <= 4'd0;
      loadn_q   <= 1'b1;
      loading_q <= 1'b0;
      loaded_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // Pulse outputs default low; each state re-asserts what it needs.
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          m_q   <= m_d;
          t_q   <= t_d;
          o_q   <= o_d;
          cnt_q <= cnt_d;
          if (start && start_ok_w) begin
            state_q   <= S_LD_M;
            data_q    <= m_d;
            loadn_q   <= 1'b0;
            loading_q <= 1'b1;
          end else begin
            data_q  <= 4'd0;
            loadn_q <= 1'b1;
            if (start) begin
              err_q <= 1'b1;
            end
          end
        end
        S_LD_M: begin
          state_q <= S_LD_T;
          data_q  <= t_q;
        end
        S_LD_T: begin
          state_q <= S_LD_O;
          data_q  <= o_q;
        end
        S_LD_O: begin
          // Entering DONE: release the bus and empty the buffer.
          state_q   <= S_DONE;
          data_q    <= 4'd0;
          loadn_q   <= 1'b1;
          loading_q <= 1'b0;
          loaded_q  <= 1'b1;
          m_q       <= 4'd0;
          t_q       <= 4'd0;
          o_q       <= 4'd0;
          cnt_q     <= 2'd0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          data_q    <= 4'd0;
          loadn_q   <= 1'b1;
          loading_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign loadn     = loadn_q;
  assign loading   = loading_q;
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign disp_mins = m_q;
  assign disp_tens = t_q;
  assign disp_ones = o_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Purpose  : Directed self-checking bench for keypad_entry. Expected load
//            digits are queued when start is issued and popped as the DUT
//            drives each loadn-low cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0;
  logic [3:0] data_out;
  logic       loadn;
  logic [3:0] disp_mins, disp_tens, disp_ones;
  logic       loading, loaded, err;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  keypad_entry dut (
    .clock     (clock),
    .clearn    (clearn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .start     (start),
    .data_out  (data_out),
    .loadn     (loadn),
    .disp_mins (disp_mins),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .loading   (loading),
    .loaded    (loaded),
    .err       (err)
  );

  always #5 clock = ~clock;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
  endtask

  function automatic logic [11:0] disp();
    return {disp_mins, disp_tens, disp_ones};
  endfunction

  // Called right after the start edge. Checks three loadn-low cycles against
  // the queued digits, then the DONE cycle and the return to IDLE.
  // inject_key drives key 2 during LD_T, which must be ignored.
  task automatic run_load(input string tag, input bit inject_key);
    int n = 0;
    while (loadn !== 1'b0 && n < 8) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 0);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      check($sformatf("%s_loadn%0d", tag, i), loadn, 1'b0);
      check($sformatf("%s_loading%0d", tag, i), loading, 1'b1);
      check($sformatf("%s_data%0d", tag, i), data_out, e);
      if (inject_key && i == 1) begin
        key_valid = 1'b1;
        key_code  = 4'd2;
      end
      step();
      key_valid = 1'b0;
    end
    check({tag, "_done_loaded"}, loaded, 1'b1);
    check({tag, "_done_loadn"}, loadn, 1'b1);
    check({tag, "_done_loading"}, loading, 1'b0);
    check({tag, "_done_disp"}, disp(), 12'h000);
    step();
    check({tag, "_idle_loaded"}, loaded, 1'b0);
    check({tag, "_idle_loadn"}, loadn, 1'b1);
  endtask

  initial begin
    // Reset
    clearn = 1'b0;
    step();
    step();
    check("rst_data", data_out, 4'd0);
    check("rst_loadn", loadn, 1'b1);
    check("rst_loading", loading, 1'b0);
    check("rst_loaded", loaded, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_disp", disp(), 12'h000);
    clearn = 1'b1;
    step();

    // Keys 1,3,0 then a normal load
    press(4'd1);
    check("key1_disp", disp(), 12'h001);
    press(4'd3);
    press(4'd0);
    check("k130_disp", disp(), 12'h130);
    exp_q.push_back(4'd1); exp_q.push_back(4'd3); exp_q.push_back(4'd0);
    start = 1'b1; step(); start = 1'b0;
    run_load("ld130", 1'b0);

    // Fourth digit dropped, ignored code, cancel
    press(4'd4); press(4'd5); press(4'd6);
    check("k456_disp", disp(), 12'h456);
    press(4'd7);
    check("drop7_disp", disp(), 12'h456);
    press(4'd12);
    check("code12_disp", disp(), 12'h456);
    press(4'd10);
    check("cancel_disp", disp(), 12'h000);

    // Start with empty buffer
    start = 1'b1; step(); start = 1'b0;
    check("empty_err", err, 1'b1);
    check("empty_loadn", loadn, 1'b1);
    check("empty_loading", loading, 1'b0);
    step();
    check("empty_err_clr", err, 1'b0);
    check("empty_loadn2", loadn, 1'b1);

    // Key and start in the same cycle
    exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd9);
    key_valid = 1'b1; key_code = 4'd9; start = 1'b1;
    step();
    key_valid = 1'b0; start = 1'b0;
    run_load("ld009", 1'b0);

    // Key during LD_T ignored
    press(4'd5); press(4'd8);
    exp_q.push_back(4'd0); exp_q.push_back(4'd5); exp_q.push_back(4'd8);
    start = 1'b1; step(); start = 1'b0;
    run_load("ldkey", 1'b1);

    // Tens digit 7
    press(4'd1); press(4'd7); press(4'd0);
    check("k170_disp", disp(), 12'h170);
`ifdef ENTRY_RANGE_CHECK_EN
    start = 1'b1; step(); start = 1'b0;
    check("rng_err", err, 1'b1);
    check("rng_loadn", loadn, 1'b1);
    check("rng_disp", disp(), 12'h170);
    step();
    check("rng_loadn2", loadn, 1'b1);
    press(4'd10);
`else
    exp_q.push_back(4'd1); exp_q.push_back(4'd7); exp_q.push_back(4'd0);
    start = 1'b1; step(); start = 1'b0;
    run_load("ld170", 1'b0);
`endif

    // All-zero entry with digits counted
    press(4'd0); press(4'd0);
`ifdef ENTRY_RANGE_CHECK_EN
    start = 1'b1; step(); start = 1'b0;
    check("zero_err", err, 1'b1);
    check("zero_loadn", loadn, 1'b1);
    step();
    press(4'd10);
`else
    exp_q.push_back(4'd0); exp_q.push_back(4'd0); exp_q.push_back(4'd0);
    start = 1'b1; step(); start = 1'b0;
    run_load("ld000", 1'b0);
`endif

    // Reset during LD_T
    press(4'd2); press(4'd4);
    start = 1'b1; step(); start = 1'b0;
    check("abort_ldm_data", data_out, 4'd0);
    step();
    check("abort_ldt_data", data_out, 4'd2);
    check("abort_ldt_loadn", loadn, 1'b0);
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    check("abort_loadn", loadn, 1'b1);
    check("abort_loading", loading, 1'b0);
    check("abort_disp", disp(), 12'h000);
    step();
    check("abort_loaded", loaded, 1'b0);
    check("abort_loadn2", loadn, 1'b1);

    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
